// File: rtl/bcd_xs3_seq_converter_if.sv
// ---------------------------------------------------------------------------
// bcd_xs3_seq_converter_if
// Handshake bundle for the sequential BCD/Excess-3 converter.
//   Input side : in_valid, in_ready, mode, in_data (DIGITS packed nibbles)
//   Output side: out_valid, out_ready, out_data, err_mask, out_error
// Modports:
//   slave  - converter view (accepts words, produces results)
//   master - environment view (produces words, consumes results)
// ---------------------------------------------------------------------------
interface bcd_xs3_seq_converter_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  mode;
    logic [4*DIGITS-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic [DIGITS-1:0]     err_mask;
    logic                  out_error;

    modport slave (
        input  in_valid,
        input  mode,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output err_mask,
        output out_error
    );

    modport master (
        output in_valid,
        output mode,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  err_mask,
        input  out_error
    );
endinterface

// File: rtl/bcd_xs3_seq_converter.sv
// ---------------------------------------------------------------------------
// bcd_xs3_seq_converter
// Multi-digit bidirectional BCD <-> Excess-3 converter. A word of DIGITS
// nibbles is accepted in IDLE, converted one digit per clock (LSB digit
// first) in CONV, and presented in DONE until the consumer takes it.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   bus       - handshake bundle (slave modport): input word/mode, result,
//               per-digit illegal mask and its OR-reduction
//   err_count - saturating count of completed transactions with an error
// ---------------------------------------------------------------------------
module bcd_xs3_seq_converter #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_xs3_seq_converter_if.slave bus,
    output logic [CNT_W-1:0]       err_count
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [W-1:0]       word_r;
    logic               mode_r;
    logic [W-1:0]       result_r;
    logic [DIGITS-1:0]  mask_r;
    logic               out_error_r;
    logic               out_valid_r;
    logic [CNT_W-1:0]   err_count_r;
    logic [3:0]         digit_s;
    logic [4:0]         conv_s;
    logic               last_s;

    // Returns {illegal, nibble}; illegal digits map to 4'hF.
    // dir = 0: BCD->XS3 (0..9 legal), dir = 1: XS3->BCD (3..12 legal).
    function automatic logic [4:0] conv_digit(input logic dir, input logic [3:0] d);
        logic [4:0] r;
        r = {1'b1, 4'hF};
        if (!dir) begin
            if (d <= 4'd9) begin
                r = {1'b0, d + 4'd3};
            end else begin
                r = {1'b1, 4'hF};
            end
        end else begin
            if ((d >= 4'd3) && (d <= 4'd12)) begin
                r = {1'b0, d - 4'd3};
            end else begin
                r = {1'b1, 4'hF};
            end
        end
        return r;
    endfunction

    // Select the current digit of the latched word and convert it.
    always_comb begin
        digit_s = word_r[{idx_r, 2'b00} +: 4];
        conv_s  = conv_digit(mode_r, digit_s);
        last_s  = (idx_r == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_s = ST_CONV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CONV;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch word on accept, fill result per digit, count errors on handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= '0;
            word_r      <= '0;
            mode_r      <= 1'b0;
            result_r    <= '0;
            mask_r      <= '0;
            out_error_r <= 1'b0;
            out_valid_r <= 1'b0;
            err_count_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        word_r      <= bus.in_data;
                        mode_r      <= bus.mode;
                        result_r    <= '0;
                        mask_r      <= '0;
                        out_error_r <= 1'b0;
                        idx_r       <= '0;
                    end
                end
                ST_CONV: begin
                    result_r[{idx_r, 2'b00} +: 4] <= conv_s[3:0];
                    mask_r[idx_r]                 <= conv_s[4];
                    // Running OR keeps out_error equal to the OR of err_mask.
                    out_error_r                   <= out_error_r | conv_s[4];
                    if (last_s) begin
                        idx_r       <= '0;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r       <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (out_error_r && (err_count_r != {CNT_W{1'b1}})) begin
                            err_count_r <= err_count_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = result_r;
    assign bus.err_mask  = mask_r;
    assign bus.out_error = out_error_r;
    assign err_count     = err_count_r;

endmodule

// File: tb/tb_bcd_xs3_seq_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_xs3_seq_converter
// Directed self-checking bench. DUT A uses DIGITS=4, CNT_W=8; DUT B uses
// DIGITS=4, CNT_W=2 to exercise the saturating error counter.
// ---------------------------------------------------------------------------
module tb_bcd_xs3_seq_converter;

    logic       clk;
    logic       rst;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    int         checks;
    int         errors;

    bcd_xs3_seq_converter_if #(.DIGITS(4)) ifa ();
    bcd_xs3_seq_converter_if #(.DIGITS(4)) ifb ();

    bcd_xs3_seq_converter #(.DIGITS(4), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifa),
        .err_count (cnt_a)
    );

    bcd_xs3_seq_converter #(.DIGITS(4), .CNT_W(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifb),
        .err_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_word(input logic m, input logic [15:0] d);
        check("in_ready_before_accept", 64'(ifa.in_ready), 64'd1);
        ifa.in_valid = 1'b1;
        ifa.mode     = m;
        ifa.in_data  = d;
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_data  = 16'hDEAD;
        ifa.mode     = ~m;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!ifa.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 64'(n), 64'd4);
    endtask

    task automatic finish_word(input logic [7:0] exp_cnt);
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        check("out_valid_after_hs", 64'(ifa.out_valid), 64'd0);
        check("in_ready_after_hs", 64'(ifa.in_ready), 64'd1);
        check("err_count", 64'(cnt_a), 64'(exp_cnt));
    endtask

    task automatic run_word(input logic m, input logic [15:0] d, input logic [15:0] exp_d,
                            input logic [3:0] exp_m, input logic [7:0] exp_cnt);
        start_word(m, d);
        wait_valid();
        check("out_data", 64'(ifa.out_data), 64'(exp_d));
        check("err_mask", 64'(ifa.err_mask), 64'(exp_m));
        check("out_error", 64'(ifa.out_error), 64'(exp_m != 4'b0000));
        finish_word(exp_cnt);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.mode = 1'b0; ifa.in_data = 16'h0000; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.mode = 1'b0; ifb.in_data = 16'h0000; ifb.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        check("rst_out_data", 64'(ifa.out_data), 64'd0);
        check("rst_err_mask", 64'(ifa.err_mask), 64'd0);
        check("rst_out_error", 64'(ifa.out_error), 64'd0);
        check("rst_err_count", 64'(cnt_a), 64'd0);

        // Legal words, both directions; mode latched per word
        run_word(1'b0, 16'h1234, 16'h4567, 4'b0000, 8'd0);
        run_word(1'b1, 16'h4567, 16'h1234, 4'b0000, 8'd0);
        run_word(1'b0, 16'h0909, 16'h3C3C, 4'b0000, 8'd0);

        // Illegal digits
        run_word(1'b0, 16'h9A05, 16'hCF38, 4'b0100, 8'd1);
        run_word(1'b1, 16'h0C3F, 16'hF90F, 4'b1001, 8'd2);

        // Backpressure in DONE with input noise
        start_word(1'b0, 16'h1234);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            ifa.in_valid = i[0];
            ifa.in_data  = 16'hABCD ^ 16'(i);
            ifa.mode     = i[1];
            tick();
            check("bp_out_valid", 64'(ifa.out_valid), 64'd1);
            check("bp_out_data", 64'(ifa.out_data), 64'h4567);
            check("bp_in_ready", 64'(ifa.in_ready), 64'd0);
        end
        ifa.in_valid = 1'b0;
        finish_word(8'd2);
        check("bp_data_held_idle", 64'(ifa.out_data), 64'h4567);

        // Reset after two digits processed
        start_word(1'b0, 16'h1111);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 64'(ifa.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(ifa.out_valid), 64'd0);
        check("mid_rst_err_count", 64'(cnt_a), 64'd0);
        check("mid_rst_err_mask", 64'(ifa.err_mask), 64'd0);
        run_word(1'b0, 16'h0000, 16'h3333, 4'b0000, 8'd0);

        // Saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            ifb.in_valid = 1'b1;
            ifb.mode     = 1'b0;
            ifb.in_data  = 16'hFFFF;
            tick();
            ifb.in_valid = 1'b0;
            n = 0;
            while (!ifb.out_valid && n < 20) begin
                tick();
                n++;
            end
            check("sat_latency", 64'(n), 64'd4);
            check("sat_err_mask", 64'(ifb.err_mask), 64'hF);
            ifb.out_ready = 1'b1;
            tick();
            ifb.out_ready = 1'b0;
            check("sat_err_count", 64'(cnt_b), (i < 3) ? 64'(i + 1) : 64'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_seq_converter.md
Name: bcd_xs3_seq_converter

Overview:
- Multi-digit, bidirectional BCD/Excess-3 code converter.
- Successor to the single-digit combinational BCD-to-Excess-3 converter.
- Accepts a packed word of DIGITS nibbles over a valid/ready handshake and converts one digit per clock, LSB digit first.
- Flags illegal digits per position, returns the result over a valid/ready handshake, and keeps a saturating error-transaction count.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (legal range 1..16).
- CNT_W, 8, width of the saturating error-transaction counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word (high only in IDLE).
- mode  input  1  0 = BCD->XS3, 1 = XS3->BCD; sampled with the word.
- in_data  input  4*DIGITS  packed digits; digit k occupies bits [4k+3:4k].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  4*DIGITS  converted digits, same packing as in_data.
- err_mask  output  DIGITS  bit k = 1 when input digit k was illegal.
- out_error  output  1  OR-reduction of err_mask.
- err_count  output  CNT_W  number of completed transactions with out_error=1, saturating.

Behaviour:
- Reset: synchronous, active-high on clk. While rst=1 at an edge:
  - state <- IDLE;
  - in_ready=1 (combinational from state) after that edge;
  - out_valid=0, out_data=0, err_mask=0, out_error=0, err_count=0;
  - digit index=0.
- rst takes priority over every other event. Reset during CONV or DONE aborts the word; no partial result is ever presented.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch in_data, latch mode, clear the result and mask registers, set index=0, go to CONV.
- CONV:
  - in_ready=0.
  - Each edge converts digit[index], writes result nibble index and err_mask[index], then increments index.
  - After the edge that processes index DIGITS-1, go to DONE.
  - Input changes during CONV have no effect, because the word and mode are latched.
- Conversion rules, mode 0 (BCD->XS3):
  - legal digit 0..9 -> digit+3 (4-bit);
  - 10..15 are illegal -> nibble 4'hF, mask bit set.
- Conversion rules, mode 1 (XS3->BCD):
  - legal digit 3..12 -> digit-3;
  - 0,1,2,13,14,15 are illegal -> nibble 4'hF, mask bit set.
- DONE:
  - out_valid=1.
  - out_data, err_mask and out_error are held stable until an edge with out_ready=1.
  - On that edge: go to IDLE, out_valid <- 0, and increment err_count if out_error=1 (saturating at all-ones, no wrap).
- out_data and err_mask keep their last values in IDLE; they are meaningful only while out_valid=1.
- Latency and throughput:
  - accept edge T -> out_valid high after edge T+DIGITS;
  - with out_ready held high, the handshake completes at edge T+DIGITS+1;
  - the next accept can occur at edge T+DIGITS+2;
  - at most one word is in flight.
- in_valid while not in IDLE is ignored; the producer must hold the word until in_ready=1.
- DIGITS=1: CONV lasts one cycle. No special case.

Test Plan:
- DIGITS=4, mode=0, in_data=16'h1234 with a one-cycle in_valid:
  - out_valid rises 4 cycles after accept;
  - out_data=16'h4567, err_mask=4'b0000, out_error=0.
- mode=1, in_data=16'h4567 -> out_data=16'h1234, err_mask=0.
  - Then mode=0 with 16'h0909 -> 16'h3C3C.
  - Checks that mode is latched per word.
- mode=0, in_data=16'h9A05:
  - out_data=16'hCF38, err_mask=4'b0100, out_error=1;
  - err_count reads 1 after the handshake.
- mode=1, in_data=16'h0C3F:
  - out_data=16'hF90F, err_mask=4'b1001, out_error=1;
  - err_count increments.
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE while toggling in_valid/in_data;
  - out_valid stays 1, out_data stays unchanged, in_ready stays 0, no new word is accepted;
  - raising out_ready gives IDLE and in_ready=1 on the next cycle.
- Reset mid-CONV:
  - assert rst for one edge after 2 digits are processed;
  - next cycle shows in_ready=1, out_valid=0, err_count=0, err_mask=0;
  - a following word 16'h0000 in mode 0 yields 16'h3333.
- Saturation, with CNT_W=2:
  - run 5 erroneous words;
  - err_count reaches 3 and stays at 3.
